// File: rtl/mca_pkg.sv
// Shared types and constants for the slice-serial adder controller.
// The optional subtract mode is enabled by defining MCA_SUB_EN.
package mca_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mca_state_e;

    localparam int unsigned MCA_WIDTH = 64;
    localparam int unsigned MCA_SLICE = 16;

    // Width of the slice index counter; never narrower than one bit.
    function automatic int unsigned mca_idx_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mca_slice_add.sv
// Combinational SLICE-bit adder slice, time-shared by the controller.
// Also reports the carry into its MSB so the caller can form signed overflow.
module mca_slice_add #(
    parameter int unsigned SLICE = 16
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             ci,
    output logic [SLICE-1:0] s,
    output logic             co,
    output logic             c_msb_in
);

    logic [SLICE:0] sum_w;

    always_comb begin
        sum_w    = {1'b0, a} + {1'b0, b} + {{SLICE{1'b0}}, ci};
        s        = sum_w[SLICE-1:0];
        co       = sum_w[SLICE];
        // Sum bit = a ^ b ^ carry-in, so the carry into the MSB falls out directly.
        c_msb_in = a[SLICE-1] ^ b[SLICE-1] ^ sum_w[SLICE-1];
    end

endmodule

// File: rtl/multicycle_add_ctrl.sv
// Multi-cycle WIDTH-bit adder: one SLICE-wide slice per clock through a single
// shared slice adder. Define MCA_SUB_EN to add the sub port (s = a - b).
module multicycle_add_ctrl
    import mca_pkg::*;
#(
    parameter int unsigned WIDTH = MCA_WIDTH,
    parameter int unsigned SLICE = MCA_SLICE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef MCA_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned N  = WIDTH / SLICE;
    localparam int unsigned KW = mca_idx_w(N);
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);

    mca_state_e       state_q, state_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic             cin_q, cin_d;
    logic             carry_q, carry_d;
    logic [KW-1:0]    k_q, k_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [SLICE-1:0] sl_s;
    logic             sl_ci;
    logic             sl_co;
    logic             sl_c_msb;
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;

    // Operands shift right each step, so the active slice is always the low SLICE bits.
    mca_slice_add #(.SLICE(SLICE)) u_slice (
        .a        (opa_q[SLICE-1:0]),
        .b        (opb_q[SLICE-1:0]),
        .ci       (sl_ci),
        .s        (sl_s),
        .co       (sl_co),
        .c_msb_in (sl_c_msb)
    );

    always_comb begin
`ifdef MCA_SUB_EN
        b_eff   = sub ? ~b : b;
        cin_eff = sub ? 1'b1 : cin;
`else
        b_eff   = b;
        cin_eff = cin;
`endif
    end

    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        cin_d   = cin_q;
        carry_d = carry_q;
        k_d     = k_q;
        s_d     = s_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        sl_ci   = (k_q == '0) ? cin_q : carry_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    opa_d   = a;
                    opb_d   = b_eff;
                    cin_d   = cin_eff;
                    k_d     = '0;
                    busy_d  = 1'b1;
                end
            end
            RUN: begin
                // Results enter at the top and land in their slice after N shifts.
                s_d     = {sl_s, s_q[WIDTH-1:SLICE]};
                opa_d   = opa_q >> SLICE;
                opb_d   = opb_q >> SLICE;
                carry_d = sl_co;
                k_d     = k_q + KW'(1);
                if (k_q == K_LAST) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    cout_d  = sl_co;
                    ovf_d   = sl_c_msb ^ sl_co;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            cin_q   <= 1'b0;
            carry_q <= 1'b0;
            k_q     <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            cin_q   <= cin_d;
            carry_q <= carry_d;
            k_q     <= k_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign s    = s_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_multicycle_add_ctrl.sv
// Self-checking bench for multicycle_add_ctrl (64-bit, 16-bit slices).
// Covers the subtract mode as well when MCA_SUB_EN is defined.
module tb_multicycle_add_ctrl;

    localparam int unsigned N_SL = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [63:0] a = '0;
    logic [63:0] b = '0;
    logic        cin = 1'b0;
`ifdef MCA_SUB_EN
    logic        sub = 1'b0;
`endif
    logic        busy;
    logic        done;
    logic [63:0] s;
    logic        cout;
    logic        ovf;

    int n_checks = 0;
    int n_fail   = 0;

    multicycle_add_ctrl #(.WIDTH(64), .SLICE(16)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef MCA_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .s     (s),
        .cout  (cout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        cin;
        logic [63:0] s;
        logic        cout;
        logic        ovf;
    } vec_t;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%016h, expected 0x%016h", nm, act, exp);
        end
    endtask

    // Reference: full-width arithmetic; subtraction is a + ~b + 1.
    task automatic model(input logic [63:0] ma, input logic [63:0] mb, input logic mc,
                         input logic msub, output logic [63:0] es, output logic ec,
                         output logic eo);
        logic [63:0] bb;
        logic [64:0] full;
        bb   = msub ? ~mb : mb;
        full = {1'b0, ma} + {1'b0, bb} + {64'd0, (msub ? 1'b1 : mc)};
        es   = full[63:0];
        ec   = full[64];
        eo   = (ma[63] == bb[63]) && (es[63] != ma[63]);
    endtask

    task automatic run_op(input logic [63:0] ta, input logic [63:0] tb_, input logic tc,
                          input logic ts, input logic [63:0] es, input logic ec,
                          input logic eo, input string nm);
        int cyc;
        logic busy_ok;
        @(negedge clk);
        a = ta; b = tb_; cin = tc; start = 1'b1;
`ifdef MCA_SUB_EN
        sub = ts;
`endif
        @(posedge clk); #1;
        start = 1'b0;
        // Scramble operands after acceptance; the result must not depend on them.
        a = {$urandom, $urandom}; b = {$urandom, $urandom}; cin = 1'($urandom);
`ifdef MCA_SUB_EN
        sub = ~ts;
`endif
        cyc = 0;
        busy_ok = 1'b1;
        while (!done && cyc < 20) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            @(posedge clk); #1;
            cyc++;
        end
        check({nm, " latency"}, 64'(cyc), 64'(N_SL));
        check({nm, " busy_run"}, {63'd0, busy_ok}, 64'd1);
        check({nm, " s"}, s, es);
        check({nm, " cout"}, {63'd0, cout}, {63'd0, ec});
        check({nm, " ovf"}, {63'd0, ovf}, {63'd0, eo});
        @(posedge clk); #1;
        check({nm, " done_clear"}, {62'd0, done, busy}, 64'd0);
        check({nm, " s_hold"}, s, es);
    endtask

    vec_t vecs[7];

    initial begin
        logic [63:0] es;
        logic        ec, eo;
        logic [63:0] ra, rb;
        logic        rc, rs;
        int          busy_cnt, done_cnt, done_at;

        vecs[0] = '{64'h0000_0000_0000_FFFF, 64'd1, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0};
        vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h0, 1'b1, 1'b0};
        vecs[2] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
        vecs[3] = '{64'h0, 64'h0, 1'b1, 64'd1, 1'b0, 1'b0};
        vecs[4] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'h0, 1'b1, 1'b1};
        vecs[5] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 64'h0, 1'b1, 1'b0};
        vecs[6] = '{64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b0,
                    64'h1234_5678_9ABC_DF00, 1'b0, 1'b0};

        // Reset with start held high: reset must win.
        rst = 1'b1; start = 1'b1; a = 64'hFFFF; b = 64'h1;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", {63'd0, busy}, 64'd0);
        check("reset done", {63'd0, done}, 64'd0);
        check("reset s", s, 64'd0);
        check("reset cout_ovf", {62'd0, cout, ovf}, 64'd0);
        @(negedge clk);
        rst = 1'b0; start = 1'b0;

        foreach (vecs[i])
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, 1'b0, vecs[i].s,
                   vecs[i].cout, vecs[i].ovf, $sformatf("vec%0d", i));

`ifdef MCA_SUB_EN
        run_op(64'd5, 64'd7, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, "sub 5-7");
        run_op(64'd7, 64'd5, 1'b1, 1'b1, 64'd2, 1'b1, 1'b0, "sub 7-5");
`endif

        // Start pulses while RUN and in the DONE cycle are ignored.
        @(negedge clk);
        a = 64'd1; b = 64'd2; cin = 1'b0; start = 1'b1;
`ifdef MCA_SUB_EN
        sub = 1'b0;
`endif
        @(posedge clk); #1;
        start = 1'b0;
        busy_cnt = busy ? 1 : 0;
        done_cnt = 0;
        done_at  = -1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (i == 2 || i == 5) begin
                start = 1'b1; a = 64'h100 * i; b = 64'h55; cin = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                done_at = i;
            end
        end
        start = 1'b0;
        check("ignore busy_cycles", 64'(busy_cnt), 64'd4);
        check("ignore done_pulses", 64'(done_cnt), 64'd1);
        check("ignore done_at", 64'(done_at), 64'(N_SL));
        check("ignore s", s, 64'd3);
        check("ignore cout_ovf", {62'd0, cout, ovf}, 64'd0);

        // Reset in the middle of RUN aborts without a done pulse.
        @(negedge clk);
        a = 64'hFFFF_FFFF_FFFF_FFFF; b = 64'h1; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort busy", {63'd0, busy}, 64'd0);
        check("abort done", {63'd0, done}, 64'd0);
        check("abort s", s, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (done || busy) done_cnt++;
        end
        check("abort no_done", 64'(done_cnt), 64'd0);
        run_op(64'h0000_0000_0000_FFFF, 64'd1, 1'b0, 1'b0,
               64'h0000_0000_0001_0000, 1'b0, 1'b0, "after_abort");

        // Randomized operations against the reference model.
        for (int i = 0; i < 40; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            if (i % 5 == 0) ra = ra | 64'h7FFF_FFFF_FFFF_0000;
            if (i % 7 == 0) rb = ~ra;
            rc = 1'($urandom);
`ifdef MCA_SUB_EN
            rs = 1'($urandom);
`else
            rs = 1'b0;
`endif
            model(ra, rb, rc, rs, es, ec, eo);
            run_op(ra, rb, rc, rs, es, ec, eo, $sformatf("rand%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
